// File: rtl/core_pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, taken-branch flush,
// data-memory wait with timeout halt, and saturating performance counters.
module core_pipe_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs_i,
    input  logic [4:0]       if_id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_ex_memread_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic             ex_branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             ex_mem_write_o,
    output logic             pc_src_branch_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             mem_wb_bubble_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    stall_cycles_q, flush_count_q;
    logic                load_use_c;
    logic                mem_stall_c;
    logic                run_eval_c;

    assign load_use_c = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                        ((id_ex_rt_i == if_id_rs_i) ||
                         (id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));
    assign mem_stall_c = dmem_req_i && !dmem_ack_i;

    // Next state and control outputs; outputs have no added latency
    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        timeout_d       = timeout_q;
        run_eval_c      = 1'b0;
        pc_write_o      = 1'b0;
        if_id_write_o   = 1'b0;
        id_ex_write_o   = 1'b0;
        ex_mem_write_o  = 1'b0;
        pc_src_branch_o = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        mem_wb_bubble_o = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (mem_stall_c) begin
                    mem_wb_bubble_o = 1'b1;
                    state_d         = ST_WAIT;
                    wait_cnt_d      = WAIT_W'(1);
                end else begin
                    run_eval_c = 1'b1;
                end
            end
            ST_WAIT: begin
                // A dropped request is treated the same as an ack
                if (mem_stall_c) begin
                    mem_wb_bubble_o = 1'b1;
                    wait_cnt_d      = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_d == WAIT_W'(TIMEOUT)) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end
                end else begin
                    run_eval_c = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_HALT: begin
                mem_wb_bubble_o = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Branch/load-use only evaluated when EX and ID are free to move
        if (run_eval_c) begin
            pc_write_o     = 1'b1;
            if_id_write_o  = 1'b1;
            id_ex_write_o  = 1'b1;
            ex_mem_write_o = 1'b1;
            if (ex_branch_taken_i) begin
                pc_src_branch_o = 1'b1;
                if_id_flush_o   = 1'b1;
                id_ex_bubble_o  = 1'b1;
            end else if (load_use_c) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end
        end

        if (rst) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            pc_src_branch_o = 1'b0;
            if_id_flush_o   = 1'b0;
            id_ex_bubble_o  = 1'b0;
            mem_wb_bubble_o = 1'b0;
        end
    end

    // State, wait counter, sticky timeout and saturating perf counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            if (!pc_write_o && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (if_id_flush_o && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign mem_timeout_o  = timeout_q;
    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;

endmodule

// File: doc/core_pipe_ctrl.md
CORE_PIPE_CTRL -- requirements
Module: core_pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum data-memory wait cycles before the block halts the pipeline (range 2..255).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the performance counters.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 if_id_rs, if_id_rt  in  5 each  SHALL carry the source registers of the instruction in ID.
REQ-006 id_uses_rt  in  1  SHALL be high when the ID instruction reads rt.
REQ-007 id_ex_memread  in  1  SHALL be high when the EX instruction is a load.
REQ-008 id_ex_rt  in  5  SHALL carry the load destination in EX.
REQ-009 ex_branch_taken  in  1  SHALL be high when EX resolves a taken branch (branch AND ALU zero).
REQ-010 dmem_req, dmem_ack  in  1 each  SHALL form the MEM-stage data-memory request/acknowledge pair.
REQ-011 pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  SHALL be the stage-register load enables.
REQ-012 pc_src_branch, if_id_flush, id_ex_bubble, mem_wb_bubble  out  1 each  SHALL select the branch target, flush IF/ID, insert a NOP into ID/EX, and insert a NOP into MEM/WB.
REQ-013 mem_timeout  out  1  SHALL be a sticky error flag.
REQ-014 stall_cycles, flush_count  out  CNT_W each  SHALL be saturating performance counters.

Function
REQ-015 The FSM SHALL have states RUN, WAIT and HALT; control outputs SHALL be combinational from the state and inputs, with no added latency.
REQ-016 The load-use hazard SHALL be defined as id_ex_memread AND id_ex_rt!=0 AND (id_ex_rt==if_id_rs OR (id_uses_rt AND id_ex_rt==if_id_rt)).
REQ-017 The memory stall SHALL be defined as dmem_req AND NOT dmem_ack.
REQ-018 RUN, no event: all write enables SHALL be 1, and all flush/bubble outputs and pc_src_branch SHALL be 0.
REQ-019 RUN, memory stall: pc_write, if_id_write, id_ex_write and ex_mem_write SHALL be 0, mem_wb_bubble SHALL be 1, the next state SHALL be WAIT, and wait_cnt SHALL load 1.
REQ-020 RUN, taken branch without a memory stall: pc_src_branch, if_id_flush and id_ex_bubble SHALL be 1, and all write enables SHALL be 1.
REQ-021 RUN, load-use hazard with no branch and no memory stall: pc_write and if_id_write SHALL be 0, id_ex_bubble SHALL be 1, and the other enables SHALL be 1; this lasts one cycle and no state change occurs.
REQ-022 Priority SHALL be memory stall > taken branch > load-use; a branch coinciding with load-use SHALL flush and SHALL NOT stall.
REQ-023 WAIT, dmem_ack=0: outputs SHALL be as in REQ-019 and wait_cnt SHALL increment; if wait_cnt==TIMEOUT, the next state SHALL be HALT and mem_timeout SHALL be set.
REQ-024 WAIT, dmem_ack=1: outputs SHALL be as in RUN evaluation (REQ-018..022, excluding the memory-stall term) and the next state SHALL be RUN.
REQ-025 Branch and load-use inputs SHALL be ignored while stalled and re-evaluated on release, because EX and ID are held.
REQ-026 HALT: all write enables SHALL be 0, mem_wb_bubble SHALL be 1, the other outputs SHALL be 0, and HALT SHALL be exited only by rst.
REQ-027 dmem_req deasserting in WAIT without ack SHALL be treated as ack (release and return to RUN).
REQ-028 stall_cycles SHALL increment each non-reset cycle in which pc_write==0, saturating at all-ones.
REQ-029 flush_count SHALL increment each cycle in which if_id_flush==1, saturating at all-ones.
REQ-030 wait_cnt SHALL be 8 bits and SHALL NOT wrap, since it stops at TIMEOUT.

Reset
REQ-031 On rst=1 at a clock edge: state SHALL become RUN, wait_cnt 0, mem_timeout 0, stall_cycles 0, flush_count 0.
REQ-032 While rst=1, all write enables, flushes, bubbles and pc_src_branch SHALL be 0.
REQ-033 rst asserted in WAIT or HALT SHALL abandon the wait; no ack is required afterwards.

Verification
REQ-034 Load-use: id_ex_memread=1, id_ex_rt=5, if_id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cycles=1.
REQ-035 Load-use to $0: id_ex_rt=0, if_id_rs=0 -> no stall.
REQ-036 Branch plus load-use in the same cycle -> pc_src_branch=1, if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1; stall_cycles unchanged.
REQ-037 dmem_req held with ack after 3 cycles -> 3 cycles with all enables 0 and mem_wb_bubble=1, release on the ack cycle, stall_cycles=3, state RUN.
REQ-038 TIMEOUT=4 with ack never asserted -> HALT after 4 cycles, mem_timeout=1, holds persist; rst -> RUN, counters 0.
REQ-039 Branch taken during WAIT -> no flush until the ack cycle, then flush once; flush_count increments by exactly 1.
